// File: rtl/alarm_scheduler.sv
// alarm_scheduler
//   Holds NB_CAPTURES alarm channels that feed an external comparator bank and
//   turns the comparator match pulses into a single handshaked event stream.
//   Each channel has an alarm value, a reload period, a one-shot/periodic mode
//   and an armed bit. An armed hit marks the channel pending (and overrun when
//   it was already pending), then either reloads the alarm (periodic, period
//   != 0) or disarms the channel. A two-state FSM presents pending channels
//   one at a time using a round-robin search that starts after the last grant.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   cfg_valid_i/ready_o configuration handshake (ready drops for one cycle
//                       after every accept)
//   cfg_ch_i            target channel; out-of-range index -> cfg_err_o pulse
//   cfg_alarm_i         first alarm value
//   cfg_period_i        reload period
//   cfg_periodic_i      1 = periodic, 0 = one-shot
//   cfg_arm_i           1 = arm, 0 = disarm
//   cfg_err_o           one-cycle pulse on a bad channel index
//   alarm_en_o          per-channel armed flags to the comparator bank
//   alarm_o             packed alarm values, channel i at [i*TIMER_BITWIDTH +: TIMER_BITWIDTH]
//   hit_i               per-channel match pulses (clk_i domain)
//   evt_valid_o/ready_i event handshake
//   evt_ch_o            channel of the presented event
//   pending_o           sticky pending flags
//   overrun_o           sticky overrun flags
module alarm_scheduler #(
  parameter int TIMER_BITWIDTH = 32,
  parameter int NB_CAPTURES    = 10,
  parameter int CH_BITS        = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               cfg_valid_i,
  output logic                               cfg_ready_o,
  input  logic [CH_BITS-1:0]                 cfg_ch_i,
  input  logic [TIMER_BITWIDTH-1:0]          cfg_alarm_i,
  input  logic [TIMER_BITWIDTH-1:0]          cfg_period_i,
  input  logic                               cfg_periodic_i,
  input  logic                               cfg_arm_i,
  output logic                               cfg_err_o,
  output logic [NB_CAPTURES-1:0]             alarm_en_o,
  output logic [TIMER_BITWIDTH*NB_CAPTURES-1:0] alarm_o,
  input  logic [NB_CAPTURES-1:0]             hit_i,
  output logic                               evt_valid_o,
  input  logic                               evt_ready_i,
  output logic [CH_BITS-1:0]                 evt_ch_o,
  output logic [NB_CAPTURES-1:0]             pending_o,
  output logic [NB_CAPTURES-1:0]             overrun_o
);

  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  logic [TIMER_BITWIDTH-1:0] alarm_q  [NB_CAPTURES];
  logic [TIMER_BITWIDTH-1:0] period_q [NB_CAPTURES];
  logic [NB_CAPTURES-1:0]    periodic_q, armed_q, pending_q, overrun_q;
  logic                      cfg_ready_q, cfg_err_q;

  state_t                    state_q, state_d;
  logic                      evt_valid_q, evt_valid_d;
  logic [CH_BITS-1:0]        evt_ch_q, evt_ch_d;
  logic [CH_BITS-1:0]        last_grant_q, last_grant_d;

  logic                      cfg_accept, cfg_ch_ok, evt_ack;
  logic [NB_CAPTURES-1:0]    cfg_load, hit_eff, ack_clr;
  logic                      grant_found;
  logic [CH_BITS-1:0]        grant_ch;

  assign cfg_accept = cfg_valid_i & cfg_ready_q;
  assign cfg_ch_ok  = (32'(cfg_ch_i) < 32'(NB_CAPTURES));
  assign evt_ack    = (state_q == PRESENT) & evt_ready_i;

  // Per-channel decode. A config on a channel wins over a same-cycle hit.
  always_comb begin
    cfg_load = '0;
    hit_eff  = '0;
    ack_clr  = '0;
    for (int i = 0; i < NB_CAPTURES; i++) begin
      cfg_load[i] = cfg_accept & (cfg_ch_i == CH_BITS'(i));
      hit_eff[i]  = hit_i[i] & armed_q[i] & ~cfg_load[i];
      ack_clr[i]  = evt_ack & (evt_ch_q == CH_BITS'(i));
    end
  end

  // Config handshake: ready is low for the cycle after each accept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_ready_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_ready_q <= ~cfg_accept;
      cfg_err_q   <= cfg_accept & ~cfg_ch_ok;
    end
  end

  // Channel state. A hit that lands on the acknowledged channel keeps it
  // pending without flagging an overrun, so the event is re-presented.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NB_CAPTURES; i++) begin
        alarm_q[i]  <= '0;
        period_q[i] <= '0;
      end
      periodic_q <= '0;
      armed_q    <= '0;
      pending_q  <= '0;
      overrun_q  <= '0;
    end else begin
      for (int i = 0; i < NB_CAPTURES; i++) begin
        if (cfg_load[i]) begin
          alarm_q[i]    <= cfg_alarm_i;
          period_q[i]   <= cfg_period_i;
          periodic_q[i] <= cfg_periodic_i;
          armed_q[i]    <= cfg_arm_i;
          overrun_q[i]  <= 1'b0;
        end else if (hit_eff[i]) begin
          if (periodic_q[i] && (period_q[i] != '0)) begin
            alarm_q[i] <= alarm_q[i] + period_q[i];
          end else begin
            armed_q[i] <= 1'b0;
          end
          if (pending_q[i] && !ack_clr[i]) begin
            overrun_q[i] <= 1'b1;
          end
        end
        if (hit_eff[i]) begin
          pending_q[i] <= 1'b1;
        end else if (ack_clr[i]) begin
          pending_q[i] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pick: lowest pending index above last_grant, else wrap to
  // the lowest pending index at or below it.
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    for (int k = 0; k < NB_CAPTURES; k++) begin
      if (!grant_found && pending_q[k] && (CH_BITS'(k) > last_grant_q)) begin
        grant_found = 1'b1;
        grant_ch    = CH_BITS'(k);
      end
    end
    for (int k = 0; k < NB_CAPTURES; k++) begin
      if (!grant_found && pending_q[k] && (CH_BITS'(k) <= last_grant_q)) begin
        grant_found = 1'b1;
        grant_ch    = CH_BITS'(k);
      end
    end
  end

  // Event FSM next state.
  always_comb begin
    state_d      = state_q;
    evt_valid_d  = evt_valid_q;
    evt_ch_d     = evt_ch_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          state_d     = PRESENT;
          evt_valid_d = 1'b1;
          evt_ch_d    = grant_ch;
        end
      end
      PRESENT: begin
        if (evt_ready_i) begin
          state_d      = IDLE;
          evt_valid_d  = 1'b0;
          last_grant_d = evt_ch_q;
        end
      end
      default: begin
        state_d     = IDLE;
        evt_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      evt_valid_q  <= 1'b0;
      evt_ch_q     <= '0;
      last_grant_q <= CH_BITS'(NB_CAPTURES - 1);
    end else begin
      state_q      <= state_d;
      evt_valid_q  <= evt_valid_d;
      evt_ch_q     <= evt_ch_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign cfg_ready_o = cfg_ready_q;
  assign cfg_err_o   = cfg_err_q;
  assign alarm_en_o  = armed_q;
  assign pending_o   = pending_q;
  assign overrun_o   = overrun_q;
  assign evt_valid_o = evt_valid_q;
  assign evt_ch_o    = evt_ch_q;

  for (genvar g = 0; g < NB_CAPTURES; g++) begin : g_alarm_out
    assign alarm_o[g*TIMER_BITWIDTH +: TIMER_BITWIDTH] = alarm_q[g];
  end

endmodule
